// File: rtl/clk_mon_pkg.sv
// -----------------------------------------------------------------------------
// clk_mon_pkg
// Shared types and helpers for the clock monitor.
//   clk_mon_state_t : monitor state machine encoding
//   calc_exp        : nominal half-period of the monitored clock in clk_in cycles
//   calc_timeout    : loss-of-clock limit, two worst-case half-periods
// -----------------------------------------------------------------------------
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } clk_mon_state_t;

    function automatic int calc_exp(input int freq_clk, input int freq_mon);
        return freq_clk / freq_mon / 2;
    endfunction

    function automatic int calc_timeout(input int freq_clk, input int freq_mon,
                                        input int tol);
        return 2 * (calc_exp(freq_clk, freq_mon) + tol);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Three-flop synchroniser for an asynchronous level, with a one-cycle strobe
// on every transition (rising or falling) of the synchronised signal.
// Ports:
//   clk_in  : sampling clock
//   aclr    : asynchronous active-high clear of the chain
//   i_async : asynchronous input level
//   o_edge  : high for one clk_in cycle per transition of i_async
// -----------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk_in,
    input  logic aclr,
    input  logic i_async,
    output logic o_edge
);

    logic r_s0;
    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk_in or posedge aclr) begin
        if (aclr) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s0 <= i_async;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
        end
    end

    // r_s0 is the metastability catcher; the edge is taken one stage later.
    assign o_edge = r_s1 ^ r_s2;

endmodule

// File: rtl/clk_mon.sv
// -----------------------------------------------------------------------------
// clk_mon
// Monitors a slow, asynchronous clock: measures each half-period in clk_in
// cycles, checks it against EXP +/- TOL and reports lock, sticky fault and
// loss-of-clock status.
// Ports:
//   clk_in      : system clock
//   aclr        : asynchronous active-high reset
//   mon_in      : monitored clock (asynchronous)
//   clr_fault   : synchronous clear of the sticky fault flag
//   half_period : last measured half-period (clk_in cycles)
//   meas_valid  : one-cycle strobe, half_period updated
//   locked      : LOCK_CNT consecutive in-range half-periods seen
//   fault       : sticky, an out-of-range half-period was seen
//   lost        : no edge for TIMEOUT cycles
//
// state  | meaning
// IDLE   | no reference edge yet (after reset or loss); next edge starts timing
// ACQ    | measuring, counting consecutive good half-periods towards lock
// LOCKED | monitored clock within tolerance
// -----------------------------------------------------------------------------
module clk_mon
    import clk_mon_pkg::*;
#(
    parameter  int FREQ_CLK = 2_000_000,
    parameter  int FREQ_MON = 250_000,
    parameter  int TOL      = 1,
    parameter  int LOCK_CNT = 4,
    localparam int EXP      = calc_exp(FREQ_CLK, FREQ_MON),
    localparam int TIMEOUT  = calc_timeout(FREQ_CLK, FREQ_MON, TOL),
    localparam int CW       = $clog2(TIMEOUT + 1)
) (
    input  logic          clk_in,
    input  logic          aclr,
    input  logic          mon_in,
    input  logic          clr_fault,
    output logic [CW-1:0] half_period,
    output logic          meas_valid,
    output logic          locked,
    output logic          fault,
    output logic          lost
);

    localparam int GW       = $clog2(LOCK_CNT + 1);
    localparam int LO_BOUND = (EXP > TOL) ? (EXP - TOL) : 0;
    localparam int HI_BOUND = EXP + TOL;

    logic            w_edge;
    logic [CW-1:0]   r_cnt;
    logic [CW:0]     w_m;
    logic [CW-1:0]   w_hp;
    logic            w_in_range;
    logic            w_cnt_full;
    logic [GW-1:0]   w_good_inc;

    clk_mon_state_t  r_state;
    logic [GW-1:0]   r_good;
    logic [CW-1:0]   r_hp;
    logic            r_valid;
    logic            r_locked;
    logic            r_fault;
    logic            r_lost;

    sync_edge_det u_sync (
        .clk_in  (clk_in),
        .aclr    (aclr),
        .i_async (mon_in),
        .o_edge  (w_edge)
    );

    // Cycles since the last edge; saturates so a dead clock holds at TIMEOUT.
    always_ff @(posedge clk_in or posedge aclr) begin
        if (aclr) begin
            r_cnt <= '0;
        end else if (w_edge) begin
            r_cnt <= '0;
        end else if (r_cnt != CW'(TIMEOUT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // The edge cycle itself is part of the half-period, hence the +1.
    assign w_m        = {1'b0, r_cnt} + (CW+1)'(1);
    // One extra bit only matters when TIMEOUT+1 is a power of two; clamp
    // rather than wrap so an overlong period never reads as a short one.
    assign w_hp       = w_m[CW] ? {CW{1'b1}} : w_m[CW-1:0];
    assign w_in_range = (w_m >= (CW+1)'(LO_BOUND)) && (w_m <= (CW+1)'(HI_BOUND));
    assign w_cnt_full = (r_cnt == CW'(TIMEOUT));
    assign w_good_inc = r_good + GW'(1);

    always_ff @(posedge clk_in or posedge aclr) begin
        if (aclr) begin
            r_state  <= IDLE;
            r_good   <= '0;
            r_hp     <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_fault  <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            // A fault set further down overrides this clear in the same cycle.
            if (clr_fault) begin
                r_fault <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    // First edge only establishes a reference; no measurement.
                    if (w_edge) begin
                        r_state <= ACQ;
                        r_good  <= '0;
                        r_lost  <= 1'b0;
                    end else if (w_cnt_full) begin
                        r_lost <= 1'b1;
                    end
                end

                ACQ: begin
                    if (w_edge) begin
                        r_valid <= 1'b1;
                        r_hp    <= w_hp;
                        if (w_in_range) begin
                            if (r_good != GW'(LOCK_CNT)) begin
                                r_good <= w_good_inc;
                            end
                            if (w_good_inc == GW'(LOCK_CNT)) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_good  <= '0;
                            r_fault <= 1'b1;
                        end
                    end else if (w_cnt_full) begin
                        r_state <= IDLE;
                        r_good  <= '0;
                        r_lost  <= 1'b1;
                    end
                end

                LOCKED: begin
                    if (w_edge) begin
                        r_valid <= 1'b1;
                        r_hp    <= w_hp;
                        if (!w_in_range) begin
                            r_state  <= ACQ;
                            r_locked <= 1'b0;
                            r_good   <= '0;
                            r_fault  <= 1'b1;
                        end
                    end else if (w_cnt_full) begin
                        r_state  <= IDLE;
                        r_locked <= 1'b0;
                        r_good   <= '0;
                        r_lost   <= 1'b1;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_locked <= 1'b0;
                    r_good   <= '0;
                end
            endcase
        end
    end

    assign half_period = r_hp;
    assign meas_valid  = r_valid;
    assign locked      = r_locked;
    assign fault       = r_fault;
    assign lost        = r_lost;

endmodule

// File: tb/tb_clk_mon.sv
// -----------------------------------------------------------------------------
// tb_clk_mon
// Scoreboard bench for clk_mon with default parameters (EXP=4, TOL=1,
// TIMEOUT=10). The stimulus drives mon_in as a list of half-periods; a
// behavioural model computes, per edge, the expected measurement and status
// and queues it. A monitor pops one entry per meas_valid strobe.
// -----------------------------------------------------------------------------
module tb_clk_mon;

    localparam int EXP      = 4;
    localparam int TOL      = 1;
    localparam int TIMEOUT  = 10;
    localparam int LOCK_CNT = 4;

    logic       clk_in    = 1'b0;
    logic       aclr      = 1'b1;
    logic       mon_in    = 1'b0;
    logic       clr_fault = 1'b0;
    logic [3:0] half_period;
    logic       meas_valid;
    logic       locked;
    logic       fault;
    logic       lost;

    clk_mon dut (
        .clk_in      (clk_in),
        .aclr        (aclr),
        .mon_in      (mon_in),
        .clr_fault   (clr_fault),
        .half_period (half_period),
        .meas_valid  (meas_valid),
        .locked      (locked),
        .fault       (fault),
        .lost        (lost)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int hp;
        bit lk;
        bit flt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: "acquired" means a reference edge exists, "streak" is
    // the run of consecutive in-range half-periods since the last break.
    bit   m_acq      = 1'b0;
    int   m_streak   = 0;
    bit   m_fault    = 1'b0;
    int   m_gap_prev = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    always @(negedge clk_in) begin
        if (!aclr && meas_valid) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                check("unexpected_meas_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("half_period", int'(half_period), e.hp);
                check("locked_at_meas", int'(locked), int'(e.lk));
                check("fault_at_meas", int'(fault), int'(e.flt));
                check("lost_at_meas", int'(lost), 0);
            end
        end
    end

    // Toggle mon_in now (caller sits on a negedge), then hold for g cycles.
    // clr_same asserts clr_fault in the cycle this toggle's edge is evaluated;
    // clr_after asserts it one cycle later.
    task automatic half(input int g, input bit clr_same, input bit clr_after);
        bit idle_edge;
        bit ok;
        bit will_to;
        bit pre_lk;
        mon_in = ~mon_in;
        idle_edge = !m_acq;
        if (!m_acq) begin
            m_acq    = 1'b1;
            m_streak = 0;
            if (clr_same) m_fault = 1'b0;
        end else begin
            ok = (m_gap_prev >= EXP - TOL) && (m_gap_prev <= EXP + TOL);
            if (ok) m_streak++;
            else    m_streak = 0;
            if (!ok)           m_fault = 1'b1;
            else if (clr_same) m_fault = 1'b0;
            sb_q.push_back('{m_gap_prev, (m_streak >= LOCK_CNT), m_fault});
        end
        if (clr_after) m_fault = 1'b0;
        pre_lk  = (m_streak >= LOCK_CNT);
        will_to = m_acq && (g >= TIMEOUT + 2);
        if (will_to) begin
            m_acq    = 1'b0;
            m_streak = 0;
        end
        m_gap_prev = g;
        for (int i = 1; i <= g; i++) begin
            @(negedge clk_in);
            clr_fault = (clr_same && i == 2) || (clr_after && i == 3);
            if (idle_edge && i == 3) check("lost_cleared_by_edge", int'(lost), 0);
            if (will_to && i == 13) begin
                check("lost_before_timeout", int'(lost), 0);
                check("locked_before_timeout", int'(locked), int'(pre_lk));
            end
            if (will_to && i == 14) begin
                check("lost_at_timeout", int'(lost), 1);
                check("locked_at_timeout", int'(locked), 0);
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_meas_valid", int'(meas_valid), 0);
        check("rst_half_period", int'(half_period), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_lost", int'(lost), 0);
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic pulse_reset();
        check("queue_empty_before_reset", sb_q.size(), 0);
        #2;
        aclr      = 1'b1;
        mon_in    = 1'b0;
        clr_fault = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk_in);
        @(negedge clk_in);
        aclr = 1'b0;
        m_acq    = 1'b0;
        m_streak = 0;
        m_fault  = 1'b0;
        sb_q.delete();
    endtask

    function automatic int pick_gap();
        int r;
        r = int'($urandom_range(0, 19));
        if (r <= 9)  return 4;
        if (r <= 11) return 3;
        if (r <= 13) return 5;
        if (r == 14) return 2;
        if (r == 15) return 6;
        if (r == 16) return 1;
        if (r == 17) return 11;
        if (r == 18) return 12;
        return 15;
    endfunction

    initial begin
        int g;
        bit cs;
        bit ca;
        #3;
        check_reset_outputs();
        @(negedge clk_in);
        @(negedge clk_in);
        aclr = 1'b0;

        // No edges at all after reset: loss reported from IDLE.
        repeat (15) @(negedge clk_in);
        check("lost_idle_no_clock", int'(lost), 1);

        // Nominal clock: lock on the 5th edge.
        repeat (8) half(4, 1'b0, 1'b0);

        // 5 and 3 tolerated, 6 breaks lock, then re-lock with fault sticky.
        half(5, 1'b0, 1'b0);
        half(3, 1'b0, 1'b0);
        half(6, 1'b0, 1'b0);
        repeat (6) half(4, 1'b0, 1'b0);

        // Clear fault, then a half-period of 2 during acquisition.
        half(6, 1'b0, 1'b0);
        half(4, 1'b0, 1'b1);
        half(4, 1'b0, 1'b0);
        half(2, 1'b0, 1'b0);
        repeat (6) half(4, 1'b0, 1'b0);

        // clr_fault coincident with an out-of-range edge, then alone.
        half(6, 1'b0, 1'b0);
        half(4, 1'b1, 1'b0);
        half(4, 1'b0, 1'b1);
        repeat (5) half(4, 1'b0, 1'b0);

        // Edge exactly at the timeout cycle: measured as 11, no loss.
        half(11, 1'b0, 1'b0);
        repeat (6) half(4, 1'b0, 1'b0);

        // Clock stops while locked, then resumes.
        half(20, 1'b0, 1'b0);
        repeat (7) half(4, 1'b0, 1'b0);

        // Reset in the middle of a locked run, then full re-acquisition.
        pulse_reset();
        repeat (8) half(4, 1'b0, 1'b0);

        // Randomised half-periods with occasional fault clears.
        for (int k = 0; k < 300; k++) begin
            g  = pick_gap();
            cs = (g >= 4) && ($urandom_range(0, 9) == 0);
            ca = (g >= 4) && !cs && ($urandom_range(0, 9) == 0);
            half(g, cs, ca);
        end
        half(4, 1'b0, 1'b0);
        clr_fault = 1'b0;

        repeat (8) @(negedge clk_in);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/clk_mon.md
Name: clk_mon

Overview:
- Receive-side companion to the clock divider: monitors a slow divided clock from another part of the board or FPGA, sampled in the clk_in domain.
- Synchronises the monitored clock, measures each half-period in clk_in cycles and checks it against the expected value ± tolerance.
- Reports locked, fault and loss-of-clock status for the supervising logic (PRD/BSK health flags).

Parameters:
- FREQ_CLK, 2_000_000, clk_in frequency in Hz
- FREQ_MON, 250_000, nominal monitored clock frequency in Hz
- TOL, 1, allowed half-period deviation in clk_in cycles
- LOCK_CNT, 4, consecutive in-range half-periods required to declare lock
- Derived localparams:
  - EXP = FREQ_CLK/FREQ_MON/2
  - TIMEOUT = 2*(EXP+TOL)
  - CW = $clog2(TIMEOUT+1)

Ports:
- clk_in  input  1  system clock
- aclr  input  1  reset, asynchronous, active-high
- mon_in  input  1  monitored clock, asynchronous to clk_in
- clr_fault  input  1  synchronous clear of sticky fault
- half_period  output  CW  last measured half-period in clk_in cycles
- meas_valid  output  1  one-cycle strobe, half_period updated
- locked  output  1  monitored clock within tolerance for ≥ LOCK_CNT half-periods
- fault  output  1  sticky: an out-of-range half-period was seen
- lost  output  1  no edge for TIMEOUT cycles

Behaviour:
- Reset is decided: aclr asynchronous, active-high; clock clk_in. Under aclr:
  - all outputs are 0
  - the sync chain and counter are cleared
  - state is IDLE
- Synchroniser:
  - 3-flop chain s0 ← mon_in, s1 ← s0, s2 ← s1.
  - edge = s1 ^ s2, so both rising and falling edges count.
- Counter cnt:
  - On an edge cycle: cnt ← 0.
  - Otherwise: cnt ← cnt+1, saturating at TIMEOUT.
  - Measured value on an edge is m = cnt+1.
- A measurement is in range when EXP−TOL ≤ m ≤ EXP+TOL.
- Latency: meas_valid and half_period are registered and update on the clock after the edge cycle.
- State machine, states IDLE, ACQ, LOCKED:
  - IDLE:
    - Edge → ACQ, good ← 0. No meas_valid on this first edge, because the previous count is meaningless.
    - lost is cleared on this edge.
  - ACQ, on edge:
    - meas_valid=1, half_period=m.
    - In range: good ← good+1. If good+1 == LOCK_CNT → LOCKED.
    - Out of range: good ← 0, fault ← 1, stay in ACQ.
  - LOCKED, on edge:
    - meas_valid=1.
    - In range: stay.
    - Out of range: fault ← 1, good ← 0 → ACQ.
  - ACQ or LOCKED with cnt reaching TIMEOUT and no edge in that cycle: → IDLE, lost ← 1.
  - IDLE with cnt reaching TIMEOUT: lost ← 1.
- locked = (state == LOCKED), registered.
- fault:
  - Set has priority over clr_fault in the same cycle.
  - clr_fault alone clears it on the next clock.
- Simultaneous edge and timeout: the edge wins and no timeout is taken.
- good counter width is $clog2(LOCK_CNT+1). It does not increment past LOCK_CNT.
- aclr mid-operation aborts immediately; there are no partial measurements afterwards.
- Glitches shorter than one clk_in period may be missed; no filtering is done beyond synchronisation.

Decomposition:
- Package clk_mon_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACQ, LOCKED} clk_mon_state_t
  - a function computing EXP and TIMEOUT from the frequencies
- Sub-module sync_edge_det: 3-flop synchroniser plus edge output, with aclr. It is reused for other asynchronous strobes.

Test Plan:
All scenarios use the default parameters, giving EXP=4, TOL=1, TIMEOUT=10 and CW=4.
- mon_in driven by a clock divider with the same FREQ values (toggles every 4 clk_in cycles) → meas_valid every 4 cycles, half_period=4; locked rises 1 cycle after the 4th valid measurement (5th edge); fault=0, lost=0.
- While locked, one half-period of 5, then 3 → locked stays 1; next half-period of 6 → fault=1, locked=0, state ACQ; 4 further good half-periods → locked=1, fault still 1.
- Lower bound: one half-period of 2 during ACQ → fault=1, good resets, so the lock needs 4 more good half-periods.
- Stop toggling mon_in while locked → lost=1 and locked=0 exactly 11 cycles after the last edge cycle; resume toggling → lost clears on the first edge with no meas_valid, and half_period=4 on the second edge.
- clr_fault asserted in the same cycle as an out-of-range edge → fault stays 1; clr_fault next cycle alone → fault=0.
- aclr pulsed mid-lock (between edges) → all outputs 0 asynchronously; after release, the first edge produces no meas_valid and lock requires 5 edges again.
